// File: rtl/neuron_act_stage.sv
// rtl/neuron_act_stage.sv - neuron activation stage: frames N_INPUTS MAC products, adds bias, requantizes, activates
// Optional build macro ACT_RELU_EN: ReLU clamp to [0, 2^(OUT_W-1)-1] instead of signed saturation.
module neuron_act_stage #(
   parameter int ACC_W    = 16,
   parameter int OUT_W    = 8,
   parameter int N_INPUTS = 4,
   parameter int SHIFT    = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             in_valid,
   input  logic [ACC_W-1:0] acc_in,
   input  logic [ACC_W-1:0] bias,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             busy,
   output logic             err
);

   localparam int CNT_W = $clog2(N_INPUTS + 1);

   // Output range expressed at the width of the shifted sum so compares stay signed and exact.
   localparam logic signed [ACC_W:0] OUT_MAX = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [ACC_W:0] OUT_MIN = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACCUM,
      S_SETTLE,
      S_CALC,
      S_HOLD
   } state_t;

   state_t              state;
   state_t              next_state;
   logic [CNT_W-1:0]    cnt;
   logic [CNT_W-1:0]    cnt_inc;
   logic [ACC_W-1:0]    base;
   logic [ACC_W-1:0]    acc_end;
   logic [ACC_W-1:0]    bias_r;
   logic                start_acc;

   logic [ACC_W-1:0]    diff;
   logic signed [ACC_W:0] sum;
   logic signed [ACC_W:0] sh;
   logic [OUT_W-1:0]    act;

   assign start_acc = (state == S_IDLE) && start;
   assign cnt_inc   = cnt + 1'b1;
   assign busy      = (state != S_IDLE);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic: count products, then settle, compute and hold until consumed.
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: begin
            if (start) begin
               next_state = (N_INPUTS == 1 && in_valid) ? S_SETTLE : S_ACCUM;
            end
         end
         S_ACCUM: begin
            if (in_valid && (cnt_inc == CNT_W'(N_INPUTS))) begin
               next_state = S_SETTLE;
            end
         end
         S_SETTLE: next_state = S_CALC;
         S_CALC:   next_state = S_HOLD;
         S_HOLD: begin
            if (out_ready) begin
               next_state = S_IDLE;
            end
         end
         default:  next_state = S_IDLE;
      endcase
   end

   // Frame sum from modular snapshot difference, bias add, floor shift and activation.
   always_comb begin
      diff = acc_end - base;
      sum  = $signed({diff[ACC_W-1], diff}) + $signed({bias_r[ACC_W-1], bias_r});
      sh   = sum >>> SHIFT;
`ifdef ACT_RELU_EN
      if (sh[ACC_W]) begin
         act = '0;
      end else if (sh > OUT_MAX) begin
         act = OUT_MAX[OUT_W-1:0];
      end else begin
         act = sh[OUT_W-1:0];
      end
`else
      if (sh > OUT_MAX) begin
         act = OUT_MAX[OUT_W-1:0];
      end else if (sh < OUT_MIN) begin
         act = OUT_MIN[OUT_W-1:0];
      end else begin
         act = sh[OUT_W-1:0];
      end
`endif
   end

   // Datapath registers: snapshots, product count and the held result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         base      <= '0;
         acc_end   <= '0;
         bias_r    <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  base   <= acc_in;
                  bias_r <= bias;
                  cnt    <= in_valid ? CNT_W'(1) : '0;
               end
            end
            S_ACCUM: begin
               if (in_valid) begin
                  cnt <= cnt_inc;
               end
            end
            S_SETTLE: begin
               acc_end <= acc_in;
            end
            S_CALC: begin
               out_data  <= act;
               out_valid <= 1'b1;
            end
            S_HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
               end
            end
            default: begin
               out_valid <= 1'b0;
            end
         endcase
      end
   end

   // Sticky protocol error: a product outside the counting window, cleared by the next accepted start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err <= 1'b0;
      end else if (start_acc) begin
         err <= 1'b0;
      end else if (in_valid && state != S_ACCUM) begin
         err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_neuron_act_stage.sv
// tb/tb_neuron_act_stage.sv - directed self-checking bench for neuron_act_stage
module tb_neuron_act_stage;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               start;
   logic               in_valid;
   logic [15:0]        acc_in;
   logic [15:0]        bias;
   logic               out_valid;
   logic               out_ready;
   logic signed [7:0]  out_data;
   logic               busy;
   logic               err;

   int n_checks = 0;
   int n_err    = 0;

`ifdef ACT_RELU_EN
   localparam int EXP_NEG     = 0;
   localparam int EXP_NEG_SAT = 0;
`else
   localparam int EXP_NEG     = -25;
   localparam int EXP_NEG_SAT = -128;
`endif

   neuron_act_stage #(
      .ACC_W(16), .OUT_W(8), .N_INPUTS(4), .SHIFT(4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
      .acc_in(acc_in), .bias(bias), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drives a 4-product frame through a registered-MAC model and checks latency and result.
   task automatic run_frame(input string tag, input logic [15:0] base_v, input logic [15:0] bias_v,
                            input int p0, input int p1, input int p2, input int p3, input int exp);
      int p [4];
      p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
      acc_in = base_v;
      bias   = bias_v;
      for (int k = 0; k < 4; k++) begin
         start    = (k == 0);
         in_valid = 1'b1;
         tick();
         start  = 1'b0;
         bias   = 16'h7FFF;
         acc_in = acc_in + 16'(p[k]);
         if (k == 0) chk({tag, "_err_clr"}, err, 0);
      end
      in_valid = 1'b0;
      chk({tag, "_settle_busy"}, busy, 1);
      chk({tag, "_settle_ov"}, out_valid, 0);
      tick();
      chk({tag, "_calc_ov"}, out_valid, 0);
      tick();
      chk({tag, "_ov"}, out_valid, 1);
      chk({tag, "_data"}, out_data, exp);
   endtask

   task automatic handshake(input string tag, input int exp);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, "_hs_ov"}, out_valid, 0);
      chk({tag, "_hs_busy"}, busy, 0);
      chk({tag, "_hs_data"}, out_data, exp);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; acc_in = '0; bias = '0; out_ready = 1'b0;
      tick(); tick();
      chk("rst_ov", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      rst_n = 1'b1;
      tick();

      run_frame("basic", 16'd0, 16'd20, 100, 100, 50, 50, 20);
      handshake("basic", 20);

      run_frame("baseline", 16'd1000, 16'd0, 40, 40, 40, 40, 10);
      start = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_ov", out_valid, 1);
         chk("bp_data", out_data, 10);
         chk("bp_busy", busy, 1);
      end
      start = 1'b0;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("hold_err", err, 1);
      chk("hold_ov", out_valid, 1);
      start = 1'b1;
      handshake("bp", 10);
      start = 1'b0;
      chk("hs_start_ignored_err", err, 1);
      tick();
      chk("idle_after_hs", busy, 0);

      run_frame("neg", 16'd500, 16'd0, -100, -100, -100, -100, EXP_NEG);
      handshake("neg", EXP_NEG);

      run_frame("satpos", 16'd0, 16'd0, 1000, 1000, 1000, 1000, 127);
      handshake("satpos", 127);

      run_frame("wrap", 16'd32000, 16'd0, 250, 250, 250, 250, 62);
      handshake("wrap", 62);

      run_frame("satneg", 16'd0, 16'd0, -1000, -1000, -1000, -1000, EXP_NEG_SAT);
      handshake("satneg", EXP_NEG_SAT);

      run_frame("pre_rst", 16'd0, 16'd0, 100, 100, 100, 100, 25);
      handshake("pre_rst", 25);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("idle_err", err, 1);

      acc_in = 16'd0;
      start = 1'b1; in_valid = 1'b1;
      tick();
      start = 1'b0; acc_in = 16'd10;
      tick();
      in_valid = 1'b0; acc_in = 16'd20;
      chk("mid_busy", busy, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mrst_ov", out_valid, 0);
      chk("mrst_data", out_data, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_err", err, 0);
      tick();
      rst_n = 1'b1;
      tick();

      run_frame("fresh", 16'd7, -16'sd16, 30, 30, 30, 30, 6);
      handshake("fresh", 6);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
